// File: rtl/mem_stage.sv
// MEM stage: byte-serial load/store unit driving an 8-bit RAM port.
// Define MEM_ALIGN_CHECK_EN to trap misaligned half/word accesses.
module mem_stage (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [4:0]  rsd_addr_in,
  input  logic [31:0] rsd_data_in,
  input  logic        write_rsd_or_not_in,
  input  logic [31:0] mem_addr_in,
  input  logic        mem_read_or_not_in,
  input  logic        mem_write_or_not_in,
  input  logic [1:0]  mem_width_in,
  input  logic        mem_unsigned_in,
  input  logic [31:0] store_data_in,
  output logic [4:0]  rsd_addr_out,
  output logic [31:0] rsd_data_out,
  output logic        write_rsd_or_not_out,
  output logic        stall_req_out,
  output logic        mem_req_out,
  input  logic        mem_gnt_in,
  output logic [31:0] mem_a_out,
  output logic [7:0]  mem_dout_out,
  output logic        mem_wr_out,
  input  logic [7:0]  mem_din_in
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        misalign_out
`endif
);

  typedef enum logic [2:0] {
    IDLE, REQ, XFER, LAST, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] sdata_q;
  logic [31:0] res_q;
  logic [31:0] ext;
  logic [1:0]  width_q;
  logic [1:0]  k_q;
  logic [1:0]  pk_q;
  logic [1:0]  k_last;
  logic [4:0]  rsd_q;
  logic        uns_q;
  logic        rd_q;
  logic        wflag_q;
  logic        pend_q;
  logic        mem_op;
  logic        misal;

  assign mem_op = mem_read_or_not_in | mem_write_or_not_in;

`ifdef MEM_ALIGN_CHECK_EN
  logic mis_q;
  assign misal = ((mem_width_in == 2'b01) && mem_addr_in[0])
              || (mem_width_in[1] && (mem_addr_in[1:0] != 2'b00));
  assign misalign_out = mis_q;
`else
  assign misal = 1'b0;
`endif

  always_comb begin
    k_last = 2'd3;
    unique case (width_q)
      2'b00:   k_last = 2'd0;
      2'b01:   k_last = 2'd1;
      default: k_last = 2'd3;
    endcase
  end

  always_comb begin
    ext = res_q;
    unique case (width_q)
      2'b00:   ext = {{24{~uns_q & res_q[7]}}, res_q[7:0]};
      2'b01:   ext = {{16{~uns_q & res_q[15]}}, res_q[15:0]};
      default: ext = res_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (mem_op) state_d = misal ? DONE : REQ;
      REQ:  if (mem_gnt_in) state_d = XFER;
      XFER: if (mem_gnt_in && (k_q == k_last))
              state_d = rd_q ? LAST : DONE;
      LAST: state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      addr_q  <= '0;
      sdata_q <= '0;
      res_q   <= '0;
      width_q <= '0;
      k_q     <= '0;
      pk_q    <= '0;
      rsd_q   <= '0;
      uns_q   <= 1'b0;
      rd_q    <= 1'b0;
      wflag_q <= 1'b0;
      pend_q  <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else if (rdy_in) begin
      state_q <= state_d;
`ifdef MEM_ALIGN_CHECK_EN
      mis_q <= (state_q == IDLE) && mem_op && misal;
`endif
      unique case (state_q)
        IDLE: if (mem_op) begin
          addr_q  <= mem_addr_in;
          sdata_q <= store_data_in;
          width_q <= mem_width_in;
          uns_q   <= mem_unsigned_in;
          rsd_q   <= rsd_addr_in;
          rd_q    <= ~mem_write_or_not_in;
          wflag_q <= write_rsd_or_not_in & ~misal;
          res_q   <= '0;
          k_q     <= '0;
          pend_q  <= 1'b0;
        end
        XFER: begin
          // byte issued last cycle lands now, granted or not
          if (pend_q) res_q[{pk_q, 3'b000} +: 8] <= mem_din_in;
          pend_q <= mem_gnt_in;
          if (mem_gnt_in) begin
            pk_q <= k_q;
            k_q  <= k_q + 2'd1;
          end
        end
        LAST: begin
          if (pend_q) res_q[{pk_q, 3'b000} +: 8] <= mem_din_in;
          pend_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rsd_addr_out         = rsd_addr_in;
    rsd_data_out         = rsd_data_in;
    write_rsd_or_not_out = write_rsd_or_not_in;
    stall_req_out        = 1'b0;
    mem_req_out          = 1'b0;
    mem_a_out            = '0;
    mem_dout_out         = '0;
    mem_wr_out           = 1'b0;
    unique case (state_q)
      IDLE: if (mem_op) begin
        stall_req_out        = 1'b1;
        write_rsd_or_not_out = 1'b0;
      end
      REQ, LAST: begin
        stall_req_out        = 1'b1;
        mem_req_out          = 1'b1;
        rsd_addr_out         = rsd_q;
        write_rsd_or_not_out = 1'b0;
      end
      XFER: begin
        stall_req_out        = 1'b1;
        mem_req_out          = 1'b1;
        rsd_addr_out         = rsd_q;
        write_rsd_or_not_out = 1'b0;
        mem_a_out            = addr_q + {30'd0, k_q};
        if (!rd_q) mem_dout_out = sdata_q[{k_q, 3'b000} +: 8];
        mem_wr_out           = ~rd_q & mem_gnt_in & rdy_in;
      end
      DONE: begin
        rsd_addr_out         = rsd_q;
        rsd_data_out         = ext;
        write_rsd_or_not_out = rd_q & wflag_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a byte-array model.
// Honours MEM_ALIGN_CHECK_EN the same way the design does.
module tb_mem_stage;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic [4:0]  rsd_addr_in = '0;
  logic [31:0] rsd_data_in = '0;
  logic        write_rsd_or_not_in = 1'b0;
  logic [31:0] mem_addr_in = '0;
  logic        mem_read_or_not_in = 1'b0;
  logic        mem_write_or_not_in = 1'b0;
  logic [1:0]  mem_width_in = '0;
  logic        mem_unsigned_in = 1'b0;
  logic [31:0] store_data_in = '0;
  logic [4:0]  rsd_addr_out;
  logic [31:0] rsd_data_out;
  logic        write_rsd_or_not_out;
  logic        stall_req_out;
  logic        mem_req_out;
  logic        mem_gnt_in = 1'b0;
  logic [31:0] mem_a_out;
  logic [7:0]  mem_dout_out;
  logic        mem_wr_out;
  logic [7:0]  mem_din_in;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign_out;
`endif

  always #5 clk_in = ~clk_in;

  mem_stage dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .rsd_addr_in(rsd_addr_in),
    .rsd_data_in(rsd_data_in),
    .write_rsd_or_not_in(write_rsd_or_not_in),
    .mem_addr_in(mem_addr_in),
    .mem_read_or_not_in(mem_read_or_not_in),
    .mem_write_or_not_in(mem_write_or_not_in),
    .mem_width_in(mem_width_in),
    .mem_unsigned_in(mem_unsigned_in),
    .store_data_in(store_data_in),
    .rsd_addr_out(rsd_addr_out),
    .rsd_data_out(rsd_data_out),
    .write_rsd_or_not_out(write_rsd_or_not_out),
    .stall_req_out(stall_req_out),
    .mem_req_out(mem_req_out),
    .mem_gnt_in(mem_gnt_in),
    .mem_a_out(mem_a_out),
    .mem_dout_out(mem_dout_out),
    .mem_wr_out(mem_wr_out),
    .mem_din_in(mem_din_in)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .misalign_out(misalign_out)
`endif
  );

  logic [7:0]  ram [0:1023];
  logic [7:0]  model_mem [0:1023];
  logic [31:0] beats [$];
  int          wr_count = 0;
  int          bad_wr = 0;
  int          total = 0;
  int          bad = 0;

  // RAM: writes on granted beats, read data one cycle after the address
  always @(posedge clk_in) begin
    if (mem_req_out && mem_gnt_in && rdy_in) beats.push_back(mem_a_out);
    if (mem_wr_out) begin
      if (!(mem_req_out && mem_gnt_in && rdy_in)) bad_wr++;
      ram[mem_a_out[9:0]] = mem_dout_out;
      wr_count++;
    end
    mem_din_in <= ram[mem_a_out[9:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] w);
    return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic is_misal(input logic [1:0] w,
                                    input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    if (w == 2'b01) return a[0];
    if (w[1]) return a[1:0] != 2'b00;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a,
                                           input int n, input logic uns);
    logic [31:0] v;
    logic [31:0] ak;
    v = 0;
    for (int k = 0; k < n; k++) begin
      ak = a + k;
      v = v + (32'(model_mem[ak[9:0]]) << (8 * k));
    end
    if (!uns && n == 1 && v >= 32'h80) v = v + 32'hFFFFFF00;
    if (!uns && n == 2 && v >= 32'h8000) v = v + 32'hFFFF0000;
    return v;
  endfunction

  function automatic logic pick_gnt(input int mode, input int cyc);
    if (mode == 1) return $urandom_range(0, 3) != 0;
    if (mode == 2) return !(cyc >= 5 && cyc <= 7);
    return 1'b1;
  endfunction

  task automatic set_nop();
    mem_read_or_not_in  = 1'b0;
    mem_write_or_not_in = 1'b0;
    mem_gnt_in          = 1'b0;
    rdy_in              = 1'b1;
  endtask

  // gmode: 0 grant always, 1 random grant, 2 grant dropped cycles 5..7
  // frz: first of two rdy-low cycles (0 = none); lat < 0 skips latency
  task automatic run_op(input logic rd, input logic wr,
                        input logic [1:0] w, input logic uns,
                        input logic [31:0] a, input logic [31:0] sd,
                        input logic [4:0] rsd, input logic wf,
                        input int gmode, input int frz, input int lat);
    int          n;
    int          cyc;
    int          wr0;
    logic        mis;
    logic        req_seen;
    logic        wbusy;
    logic [31:0] ak;
    logic [31:0] exp;
    n   = nbytes(w);
    mis = is_misal(w, a);
    @(negedge clk_in);
    mem_read_or_not_in  = rd;
    mem_write_or_not_in = wr;
    mem_width_in        = w;
    mem_unsigned_in     = uns;
    mem_addr_in         = a;
    store_data_in       = sd;
    rsd_addr_in         = rsd;
    rsd_data_in         = $urandom;
    write_rsd_or_not_in = wf;
    rdy_in              = 1'b1;
    beats.delete();
    wr0      = wr_count;
    req_seen = 1'b0;
    wbusy    = 1'b0;
    cyc      = 1;
    mem_gnt_in = pick_gnt(gmode, cyc);
    #1;
    chk("stall_accept", 32'(stall_req_out), 32'd1);
    while (cyc < 200) begin
      @(negedge clk_in);
      cyc++;
      mem_gnt_in = pick_gnt(gmode, cyc);
      rdy_in = !(frz > 0 && cyc >= frz && cyc < frz + 2);
      #1;
      if (!rdy_in) chk("frozen_wr", 32'(mem_wr_out), 32'd0);
      if (!stall_req_out) break;
      if (write_rsd_or_not_out) wbusy = 1'b1;
      if (mem_req_out) req_seen = 1'b1;
    end
    if (cyc >= 200) begin
      chk("timeout", 32'(cyc), 32'd0);
    end else begin
      if (lat >= 0) chk("latency", 32'(cyc), 32'(lat));
      chk("busy_wflag", 32'(wbusy), 32'd0);
      chk("done_rsd", 32'(rsd_addr_out), 32'(rsd));
      chk("done_wflag", 32'(write_rsd_or_not_out),
          32'((rd && !wr && !mis) ? wf : 1'b0));
      if (mis) begin
        chk("mis_req", 32'(req_seen), 32'd0);
        chk("mis_beats", 32'(beats.size()), 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
        chk("mis_pulse", 32'(misalign_out), 32'd1);
`endif
      end else begin
        chk("beat_count_ok", 32'(beats.size() >= n + 1), 32'd1);
        if (beats.size() >= n + 1)
          for (int k = 0; k < n; k++) chk("beat_addr", beats[k + 1], a + k);
        if (rd && !wr) begin
          exp = exp_load(a, n, uns);
          chk("load_data", rsd_data_out, exp);
        end else begin
          chk("store_writes", 32'(wr_count - wr0), 32'(n));
          for (int k = 0; k < n; k++) begin
            ak = a + k;
            model_mem[ak[9:0]] = 8'(sd >> (8 * k));
            chk("store_byte", 32'(ram[ak[9:0]]), 32'(model_mem[ak[9:0]]));
          end
        end
      end
    end
    @(negedge clk_in);
    set_nop();
    #1;
    chk("idle_stall", 32'(stall_req_out), 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_cleared", 32'(misalign_out), 32'd0);
`endif
  endtask

  initial begin
    logic [31:0] r;
    logic [1:0]  w;
    logic        rd;
    logic        wr;
    for (int i = 0; i < 1024; i++) begin
      ram[i]       = 8'($urandom);
      model_mem[i] = ram[i];
    end
    r = 32'h12345678;
    for (int k = 0; k < 4; k++) begin
      ram[10'h100 + k]       = 8'(r >> (8 * k));
      model_mem[10'h100 + k] = 8'(r >> (8 * k));
    end
    ram[10'h300]       = 8'h80;
    model_mem[10'h300] = 8'h80;

    write_rsd_or_not_in = 1'b1;
    rsd_data_in         = 32'h5A5A1234;
    rsd_addr_in         = 5'd7;
    #12;
    chk("rst_req", 32'(mem_req_out), 32'd0);
    chk("rst_wr", 32'(mem_wr_out), 32'd0);
    chk("rst_a", mem_a_out, 32'd0);
    chk("rst_dout", 32'(mem_dout_out), 32'd0);
    chk("rst_stall", 32'(stall_req_out), 32'd0);
    chk("rst_pass", rsd_data_out, 32'h5A5A1234);
`ifdef MEM_ALIGN_CHECK_EN
    chk("rst_mis", 32'(misalign_out), 32'd0);
`endif
    @(negedge clk_in);
    rst_in = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      rsd_addr_in         = 5'($urandom);
      rsd_data_in         = $urandom;
      write_rsd_or_not_in = 1'($urandom);
      #1;
      chk("nop_addr", 32'(rsd_addr_out), 32'(rsd_addr_in));
      chk("nop_data", rsd_data_out, rsd_data_in);
      chk("nop_wflag", 32'(write_rsd_or_not_out), 32'(write_rsd_or_not_in));
      chk("nop_stall", 32'(stall_req_out), 32'd0);
    end

    run_op(1, 0, 2'b10, 0, 32'h100, 0, 5'd3, 1, 0, 0, 8);
    run_op(1, 0, 2'b00, 0, 32'h300, 0, 5'd4, 1, 0, 0, 5);
    run_op(1, 0, 2'b00, 1, 32'h300, 0, 5'd5, 1, 0, 0, 5);
    run_op(0, 1, 2'b01, 0, 32'h200, 32'hABCD1234, 5'd6, 1, 0, 0, 5);
    chk("sh_byte0", 32'(ram[10'h200]), 32'h34);
    chk("sh_byte1", 32'(ram[10'h201]), 32'h12);
    run_op(1, 0, 2'b10, 0, 32'h100, 0, 5'd8, 1, 2, 0, 11);
    run_op(0, 1, 2'b10, 0, 32'h180, 32'hDEADBEEF, 5'd9, 0, 0, 4, 9);
    run_op(1, 1, 2'b00, 0, 32'h190, 32'h000000C3, 5'd10, 1, 0, 0, 4);
    run_op(1, 0, 2'b11, 0, 32'h180, 0, 5'd11, 1, 0, 0, 8);

    // reset in the middle of a word store
    @(negedge clk_in);
    mem_read_or_not_in  = 1'b0;
    mem_write_or_not_in = 1'b1;
    mem_width_in        = 2'b10;
    mem_addr_in         = 32'h240;
    store_data_in       = 32'hCAFEF00D;
    mem_gnt_in          = 1'b1;
    repeat (3) @(negedge clk_in);
    #1;
    chk("pre_rst_wr", 32'(mem_wr_out), 32'd1);
    rst_in = 1'b0;
    #1;
    chk("abort_wr", 32'(mem_wr_out), 32'd0);
    chk("abort_req", 32'(mem_req_out), 32'd0);
    chk("abort_a", mem_a_out, 32'd0);
    @(negedge clk_in);
    set_nop();
    rst_in = 1'b1;
    model_mem[10'h240] = 8'h0D;
    chk("abort_b0", 32'(ram[10'h240]), 32'h0D);
    chk("abort_b1", 32'(ram[10'h241]), 32'(model_mem[10'h241]));
    run_op(1, 0, 2'b00, 1, 32'h241, 0, 5'd12, 1, 0, 0, 5);

`ifdef MEM_ALIGN_CHECK_EN
    run_op(1, 0, 2'b10, 0, 32'h102, 0, 5'd13, 1, 0, 0, 2);
    run_op(0, 1, 2'b01, 0, 32'h201, 32'h5555, 5'd14, 0, 0, 0, 2);
`else
    run_op(1, 0, 2'b10, 0, 32'h102, 0, 5'd13, 1, 0, 0, 8);
`endif

    for (int i = 0; i < 60; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = rd ? ($urandom_range(0, 3) == 0) : 1'b1;
      w  = 2'($urandom_range(0, 3));
      run_op(rd, wr, w, 1'($urandom), $urandom, $urandom,
             5'($urandom), 1'($urandom), 1, 0, -1);
    end

    chk("wr_without_gnt", 32'(bad_wr), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk_in  in  1  rising-edge clock.
REQ-003 rst_in  in  1  asynchronous, active-low reset.
REQ-004 rdy_in  in  1  global ready; low freezes all state.
REQ-005 Pipeline inputs from the EX/MEM register:
- rsd_addr_in[4:0], rsd_data_in[31:0], write_rsd_or_not_in
- mem_addr_in[31:0], mem_read_or_not_in, mem_write_or_not_in
- mem_width_in[1:0] (00 byte, 01 half, 10 word; 11 treated as word)
- mem_unsigned_in
- store_data_in[31:0]
REQ-006 Outputs to MEM/WB: rsd_addr_out[4:0], rsd_data_out[31:0], write_rsd_or_not_out.
REQ-007 stall_req_out  out  1  high stalls stages 0-4 while an access is in progress.
REQ-008 Byte-RAM port:
- mem_req_out (out 1), mem_gnt_in (in 1)
- mem_a_out (out 32), mem_dout_out (out 8)
- mem_wr_out (out 1), mem_din_in (in 8)
- Read data for an address issued in cycle N is valid on mem_din_in in cycle N+1.
REQ-009 misalign_out  out  1  misalignment pulse; exists only under MEM_ALIGN_CHECK_EN.

Function
REQ-010 Non-memory ops (read and write both low) SHALL pass rsd_* inputs to the outputs combinationally, with stall_req_out=0.
REQ-011 FSM states SHALL be IDLE, REQ, XFER, LAST, DONE.
REQ-012 IDLE with a memory op SHALL do all of the following:
- assert stall_req_out combinationally;
- latch address, width, data, unsigned flag and rsd_addr;
- go to REQ.
REQ-013 mem_req_out SHALL be high in REQ, XFER and LAST.
REQ-014 REQ SHALL go to XFER on the first cycle mem_gnt_in=1.
REQ-015 XFER SHALL issue one byte per cycle with mem_gnt_in=1.
- byte k uses mem_a_out = addr+k, mod 2^32.
- k runs 0..n-1, with n = 1, 2 or 4.
- Stores SHALL drive mem_dout_out = store_data[8k+7:8k] with mem_wr_out=1.
REQ-016 Reads SHALL capture mem_din_in into result bits [8k+7:8k] in the cycle after byte k is issued. Bytes are little-endian.
REQ-017 If mem_gnt_in falls in XFER, the block SHALL do all of the following:
- hold k;
- drive mem_wr_out=0;
- still capture the read byte already pending.
REQ-018 After the last byte, a read SHALL go to LAST (final capture) and then to DONE; a store SHALL go directly to DONE.
REQ-019 DONE SHALL drive stall_req_out=0 for exactly one cycle, then return to IDLE.
- Read: write_rsd_or_not_out=latched flag; rsd_data_out = result, sign-extended or zero-extended to 32 bits from the access width.
- Store: write_rsd_or_not_out=0.
REQ-020 During REQ, XFER and LAST, write_rsd_or_not_out SHALL be 0.
REQ-021 With rdy_in=0, all state SHALL be frozen and mem_wr_out=0.
REQ-022 If read and write are both high, the op SHALL be treated as a store.
REQ-023 Cycle count for LW with mem_gnt_in held high SHALL be 8 from acceptance to the DONE output: IDLE 1, REQ 1, XFER 4, LAST 1, DONE 1.

Reset
REQ-024 When rst_in=0, the block SHALL asynchronously set:
- state IDLE, k=0;
- mem_req_out=0, mem_wr_out=0, mem_a_out=0, mem_dout_out=0;
- registered result, misalign_out and write flag all 0.
REQ-025 A reset during XFER SHALL abort the access with no further writes; partially written bytes are not rolled back.
REQ-026 After reset deasserts, the first accepted op SHALL start from k=0.

Configuration
REQ-027 The macro MEM_ALIGN_CHECK_EN SHALL compile in alignment checking.
REQ-028 With MEM_ALIGN_CHECK_EN defined:
- Trigger: a half access with addr[0]=1, or a word access with addr[1:0]!=0.
- Action: skip REQ/XFER, go IDLE->DONE, pulse misalign_out for 1 cycle.
- Result: write_rsd_or_not_out=0; no bus activity.
REQ-029 Without MEM_ALIGN_CHECK_EN, misalign_out SHALL NOT exist, and misaligned accesses SHALL proceed bytewise per REQ-015.

Verification
REQ-030 LW from 0x100 holding bytes 78,56,34,12, with gnt high -> addresses 0x100..0x103, DONE at cycle 8, rsd_data_out=0x12345678.
REQ-031 LB from a byte 0x80, signed -> 0xFFFFFF80; LBU from the same byte -> 0x00000080.
REQ-032 SH 0xABCD1234 to 0x200 -> two writes, 0x200=0x34 and 0x201=0x12; write_rsd_or_not_out=0 at DONE.
REQ-033 LW with gnt dropped for 3 cycles after byte 1 -> no duplicated or lost bytes; correct word returned; total latency 11.
REQ-034 rst_in pulled low during XFER of SW -> mem_wr_out=0 immediately, state IDLE; a following LBU completes normally.
REQ-035 With MEM_ALIGN_CHECK_EN, LW at 0x102 -> misalign_out pulses 1 cycle, no mem_req_out, stall_req_out low after 1 cycle.
